// File: rtl/qa_drv_line_to_chunk_stream.sv
// qa_drv_line_to_chunk_stream: deframes an in-order cache-line stream into UMF chunks with end-of-message flags,
// tracking consumed lines, completed messages and oversize headers.
module qa_drv_line_to_chunk_stream #(
    parameter int LINE_WIDTH  = 512,
    parameter int CHUNK_WIDTH = 128,
    parameter int LEN_BITS    = 16,
    parameter int MAX_CHUNKS  = 4096,
    parameter int IDX_BITS    = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LINE_WIDTH-1:0]  line_in,
    input  logic                   line_valid,
    output logic                   line_deq,
    output logic [CHUNK_WIDTH-1:0] chunk_data,
    output logic                   chunk_eom,
    output logic                   chunk_valid,
    input  logic                   chunk_deq,
    output logic [IDX_BITS-1:0]    oldest_line_idx,
    output logic [31:0]            msg_count,
    output logic                   err_oversize
);
    localparam int CPL      = LINE_WIDTH / CHUNK_WIDTH;
    localparam int CIL_BITS = $clog2(CPL);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_STREAM, S_WAIT_LINE, S_ERROR} state_t;

    state_t                 r_state, w_state_nxt;
    logic [LINE_WIDTH-1:0]  r_cur, w_cur_nxt;
    logic [LEN_BITS-1:0]    r_remaining, w_remaining_nxt;
    logic [CIL_BITS-1:0]    r_cil, w_cil_nxt;
    logic [31:0]            r_msg_count;
    logic                   r_err;
    logic [IDX_BITS-1:0]    r_idx;
    logic [CHUNK_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]             r_fifo_eom;
    logic                   r_wr_ptr, r_rd_ptr;
    logic [1:0]             r_fifo_cnt;
    logic [LEN_BITS-1:0]    w_hdr_len;
    logic                   w_emit, w_eom, w_msg_done, w_set_err, w_pop, w_full;

    assign w_hdr_len       = r_cur[LEN_BITS-1:0];
    assign w_full          = r_fifo_cnt[1];
    assign chunk_valid     = r_fifo_cnt != 2'd0;
    assign w_pop           = chunk_deq & chunk_valid;
    assign chunk_data      = chunk_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign chunk_eom       = chunk_valid & r_fifo_eom[r_rd_ptr];
    assign oldest_line_idx = r_idx;
    assign msg_count       = r_msg_count;
    assign err_oversize    = r_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_remaining_nxt = r_remaining;
        w_cil_nxt       = r_cil;
        line_deq        = 1'b0;
        w_emit          = 1'b0;
        w_eom           = 1'b0;
        w_msg_done      = 1'b0;
        w_set_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (line_valid) begin
                    line_deq    = 1'b1;
                    w_cur_nxt   = line_in;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                w_cur_nxt = r_cur >> CHUNK_WIDTH;
                if (w_hdr_len == '0) begin
                    w_msg_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_hdr_len > LEN_BITS'(MAX_CHUNKS)) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_remaining_nxt = w_hdr_len;
                    w_cil_nxt       = CIL_BITS'(1);
                    w_state_nxt     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!w_full) begin
                    w_emit    = 1'b1;
                    w_eom     = r_remaining == LEN_BITS'(1);
                    w_cur_nxt = r_cur >> CHUNK_WIDTH;
                    w_cil_nxt = r_cil + CIL_BITS'(1);
                    if (w_eom) begin
                        w_msg_done  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_remaining_nxt = r_remaining - LEN_BITS'(1);
                        // Last chunk of this line: fetch the next one in the same cycle to avoid a bubble.
                        if (r_cil == CIL_BITS'(CPL - 1)) begin
                            if (line_valid) begin
                                line_deq  = 1'b1;
                                w_cur_nxt = line_in;
                            end else begin
                                w_state_nxt = S_WAIT_LINE;
                            end
                        end
                    end
                end
            end
            S_WAIT_LINE: begin
                if (line_valid) begin
                    line_deq    = 1'b1;
                    w_cur_nxt   = line_in;
                    w_cil_nxt   = '0;
                    w_state_nxt = S_STREAM;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_remaining <= '0;
            r_cil       <= '0;
            r_msg_count <= '0;
            r_err       <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_remaining <= w_remaining_nxt;
            r_cil       <= w_cil_nxt;
            r_msg_count <= r_msg_count + 32'(w_msg_done);
            r_err       <= r_err | w_set_err;
            r_idx       <= r_idx + IDX_BITS'(line_deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_eom     <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_fifo_cnt     <= '0;
        end else begin
            if (w_emit) begin
                r_fifo_data[r_wr_ptr] <= r_cur[CHUNK_WIDTH-1:0];
                r_fifo_eom[r_wr_ptr]  <= w_eom;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_fifo_cnt <= r_fifo_cnt + 2'(w_emit) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_qa_drv_line_to_chunk_stream.sv
// tb_qa_drv_line_to_chunk_stream: message-level model of the deframer (expected chunk queue, line and message
// totals) checked every cycle, plus directed literal checks on latency, throughput, backpressure, errors and reset.
module tb_qa_drv_line_to_chunk_stream;
    localparam int LW = 64, CW = 16, CPL = LW / CW, IB = 2, MAXC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [LW-1:0] line_in;
    logic          line_valid, line_deq;
    logic [CW-1:0] chunk_data;
    logic          chunk_eom, chunk_valid;
    logic          chunk_deq = 1'b1;
    logic [IB-1:0] oldest_line_idx;
    logic [31:0]   msg_count;
    logic          err_oversize;

    int            n_chk = 0, n_fail = 0;
    logic [LW-1:0] src_q[$];
    bit            src_en = 1'b0;
    logic [CW:0]   exp_q[$];
    int            exp_lines = 0, exp_msgs = 0;
    bit            exp_err = 1'b0;

    always #5 clk = ~clk;

    qa_drv_line_to_chunk_stream #(
        .LINE_WIDTH(LW), .CHUNK_WIDTH(CW), .LEN_BITS(16), .MAX_CHUNKS(MAXC), .IDX_BITS(IB)
    ) dut (
        .clk(clk), .reset(reset), .line_in(line_in), .line_valid(line_valid), .line_deq(line_deq),
        .chunk_data(chunk_data), .chunk_eom(chunk_eom), .chunk_valid(chunk_valid), .chunk_deq(chunk_deq),
        .oldest_line_idx(oldest_line_idx), .msg_count(msg_count), .err_oversize(err_oversize)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A message is a header chunk N followed by N payload chunks, padded out to whole lines.
    task automatic push_msg(input int n, input logic [15:0] base);
        logic [15:0]   c[$];
        logic [LW-1:0] ln;
        c.push_back(16'(n));
        for (int k = 1; k <= n; k++) begin
            c.push_back(base + 16'(k));
            exp_q.push_back({base + 16'(k), k == n});
        end
        while (c.size() % CPL != 0) c.push_back(16'hEEEE);
        for (int l = 0; l < c.size() / CPL; l++) begin
            ln = '0;
            for (int j = 0; j < CPL; j++) ln[j*CW +: CW] = c[l*CPL + j];
            src_q.push_back(ln);
        end
        exp_lines += (n + CPL) / CPL;
        exp_msgs++;
    endtask

    task automatic push_oversize(input int n);
        logic [LW-1:0] ln;
        ln = {LW{1'b1}};
        ln[CW-1:0] = 16'(n);
        src_q.push_back(ln);
        src_q.push_back({LW{1'b0}});
        exp_lines++;
        exp_err = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && src_q.size() == 0 && !chunk_valid;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got busy, expected idle within 300 cycles", name);
        end
        repeat (3) @(negedge clk);
        chk({name, "_idx"}, 64'(oldest_line_idx), 64'(exp_lines % (1 << IB)));
        chk({name, "_msgs"}, 64'(msg_count), 64'(exp_msgs));
        chk({name, "_err"}, 64'(err_oversize), 64'(exp_err));
    endtask

    task automatic find_chunk(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = chunk_valid;
        end
        chk({name, "_chunk_seen"}, 64'(found), 64'd1);
    endtask

    task automatic clear_model();
        src_q.delete();
        exp_q.delete();
        exp_lines = 0;
        exp_msgs  = 0;
        exp_err   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_valid"}, 64'(chunk_valid), 64'd0);
        chk({name, "_data"}, 64'(chunk_data), 64'd0);
        chk({name, "_eom"}, 64'(chunk_eom), 64'd0);
        chk({name, "_deq"}, 64'(line_deq), 64'd0);
        chk({name, "_idx"}, 64'(oldest_line_idx), 64'd0);
        chk({name, "_msgs"}, 64'(msg_count), 64'd0);
        chk({name, "_err"}, 64'(err_oversize), 64'd0);
    endtask

    // Line source: presents the head of src_q and retires it on the cycle the DUT dequeues.
    initial begin
        bit took;
        line_valid = 1'b0;
        line_in    = '0;
        forever begin
            @(negedge clk);
            took = line_deq;
            if (line_deq) chk("deq_needs_valid", 64'(line_valid), 64'd1);
            @(posedge clk);
            if (took && src_q.size() > 0) void'(src_q.pop_front());
            #2;
            line_valid = src_en && src_q.size() != 0;
            line_in    = line_valid ? src_q[0] : '0;
        end
    end

    // Chunk scoreboard: every delivered chunk must be the next expected {data, eom}.
    initial begin
        logic [CW:0] e;
        forever begin
            @(negedge clk);
            if (!reset && chunk_valid && chunk_deq) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stream_extra: got chunk 0x%0h eom %0d, expected no chunk", chunk_data, chunk_eom);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream", 64'({chunk_data, chunk_eom}), 64'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int cnt;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk); #1;
        reset  = 1'b0;
        src_en = 1'b1;

        // Single line, N=3: first chunk three cycles after line_valid, back-to-back payload.
        push_msg(3, 16'h1000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = line_valid;
        end
        chk("t1_line_valid", 64'(found), 64'd1);
        @(negedge clk); chk("t1_cv_t1", 64'(chunk_valid), 64'd0);
        @(negedge clk); chk("t1_cv_t2", 64'(chunk_valid), 64'd0);
        @(negedge clk); chk("t1_a", 64'({chunk_valid, chunk_data, chunk_eom}), 64'({1'b1, 16'h1001, 1'b0}));
        @(negedge clk); chk("t1_b", 64'({chunk_valid, chunk_data, chunk_eom}), 64'({1'b1, 16'h1002, 1'b0}));
        @(negedge clk); chk("t1_c", 64'({chunk_valid, chunk_data, chunk_eom}), 64'({1'b1, 16'h1003, 1'b1}));
        wait_idle("t1");
        chk("t1_idx_lit", 64'(oldest_line_idx), 64'd1);
        chk("t1_msgs_lit", 64'(msg_count), 64'd1);

        // N=6 across two lines: six consecutive chunks, no bubble at the line boundary.
        push_msg(6, 16'h2000);
        find_chunk("t2");
        chk("t2_c1", 64'({chunk_data, chunk_eom}), 64'({16'h2001, 1'b0}));
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk("t2_run", 64'({chunk_valid, chunk_data, chunk_eom}), 64'({1'b1, 16'h2000 + 16'(k), k == 6}));
        end
        wait_idle("t2");
        chk("t2_idx_lit", 64'(oldest_line_idx), 64'd3);

        // Zero-length message then N=1.
        push_msg(0, 16'h3000);
        push_msg(1, 16'h3100);
        find_chunk("t3");
        chk("t3_only", 64'({chunk_data, chunk_eom}), 64'({16'h3101, 1'b1}));
        wait_idle("t3");
        chk("t3_msgs_lit", 64'(msg_count), 64'd4);
        chk("t3_idx_lit", 64'(oldest_line_idx), 64'd1);

        // Backpressure: two chunks buffer up, the stream stalls before the second line.
        @(posedge clk); #1;
        chunk_deq = 1'b0;
        push_msg(5, 16'h4000);
        repeat (10) @(negedge clk);
        chk("t4_stall_head", 64'({chunk_valid, chunk_data, chunk_eom}), 64'({1'b1, 16'h4001, 1'b0}));
        chk("t4_stall_idx", 64'(oldest_line_idx), 64'd2);
        chk("t4_stall_lv", 64'({line_valid, line_deq}), 64'({1'b1, 1'b0}));
        @(posedge clk); #1;
        chunk_deq = 1'b1;
        @(negedge clk); chk("t4_rel1", 64'(chunk_data), 64'h4001);
        @(negedge clk); chk("t4_rel2", 64'(chunk_data), 64'h4002);
        wait_idle("t4");
        chk("t4_msgs_lit", 64'(msg_count), 64'd5);

        // N=MAX_CHUNKS is legal and spans three lines.
        push_msg(MAXC, 16'h5000);
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (chunk_valid) begin
                cnt++;
                found = chunk_eom;
            end
        end
        chk("t5_count_to_eom", 64'(cnt), 64'(MAXC));
        wait_idle("t5");
        chk("t5_idx_lit", 64'(oldest_line_idx), 64'd2);

        // Oversize header: sticky error, no output, further lines left unconsumed.
        push_oversize(MAXC + 1);
        repeat (10) @(negedge clk);
        chk("t6_err", 64'(err_oversize), 64'd1);
        chk("t6_cv", 64'(chunk_valid), 64'd0);
        chk("t6_lv_deq", 64'({line_valid, line_deq}), 64'({1'b1, 1'b0}));
        chk("t6_idx", 64'(oldest_line_idx), 64'd3);
        chk("t6_msgs", 64'(msg_count), 64'd6);
        @(posedge clk); #1;
        src_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        clear_model();
        @(posedge clk); #1;
        reset  = 1'b0;
        src_en = 1'b1;

        // Five single-line messages from reset wrap the 2-bit line index to 1.
        push_msg(1, 16'h6100);
        push_msg(2, 16'h6200);
        push_msg(3, 16'h6300);
        push_msg(1, 16'h6400);
        push_msg(3, 16'h6500);
        wait_idle("t7");
        chk("t7_idx_lit", 64'(oldest_line_idx), 64'd1);
        chk("t7_msgs_lit", 64'(msg_count), 64'd5);

        // Reset in the middle of the second message, then a clean decode.
        push_msg(2, 16'h7000);
        push_msg(MAXC, 16'h8000);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = chunk_valid && chunk_data == 16'h8001;
        end
        chk("t8_mid_seen", 64'(found), 64'd1);
        @(posedge clk); #1;
        src_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check_reset_outputs("t8_rst");
        clear_model();
        @(posedge clk); #1;
        reset  = 1'b0;
        src_en = 1'b1;
        push_msg(4, 16'h9000);
        find_chunk("t8");
        chk("t8_first", 64'({chunk_data, chunk_eom}), 64'({16'h9001, 1'b0}));
        wait_idle("t8");
        chk("t8_idx_lit", 64'(oldest_line_idx), 64'd2);
        chk("t8_msgs_lit", 64'(msg_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
